// File: rtl/req_capture.sv
// ---------------------------------------------------------------------------
// req_capture
//
// Request-capture stage in front of the 4-to-2 priority encoder. Four raw,
// asynchronous request lines are each synchronised, debounced and then
// edge-detected. A debounced rising edge latches a pending bit. The pending
// vector feeds the encoder's a[3:0] input. When the consumer services a
// request it acknowledges with the serviced index, and that pending bit is
// cleared. A request that arrives while its channel is still pending raises a
// sticky overflow flag.
//
// Ports
//   clk        in   1  single clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   req_in     in   4  raw asynchronous request lines, active-high
//   ack_valid  in   1  one-cycle pulse: request ack_idx has been serviced
//   ack_idx    in   2  index of the serviced request (valid with ack_valid)
//   ovf_clr    in   1  clears all overflow flags on the next edge
//   pend       out  4  registered pending vector (encoder a[3:0])
//   any_pend   out  1  OR of pend, no extra latency
//   ovf        out  4  registered sticky per-channel overflow flags
//
// Latency: the first edge that samples a new req_in level is edge 1. A held
// level is accepted, and pend updates, on edge DEBOUNCE_CYCLES+2.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module req_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  // Derived from DEBOUNCE_CYCLES; leave at its default.
  parameter int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_in,
  input  logic       ack_valid,
  input  logic [1:0] ack_idx,
  input  logic       ovf_clr,
  output logic [3:0] pend,
  output logic       any_pend,
  output logic [3:0] ovf
);

  localparam int unsigned NCH = 4;

  // The count value at which a differing level is accepted on that edge.
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchroniser stages.
  logic [NCH-1:0] s1;
  logic [NCH-1:0] s2;

  // Debounced (accepted) level and per-channel stability counters.
  logic [NCH-1:0] stable;
  logic [CW-1:0]  cnt [NCH];

  // Per-channel events for this cycle.
  logic [NCH-1:0] accept;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] clr;

  // Next-state values of the registered outputs.
  logic [NCH-1:0] pend_next;
  logic [NCH-1:0] ovf_next;

  // -------------------------------------------------------------------------
  // Synchroniser. req_in is used nowhere else.
  // -------------------------------------------------------------------------
  // NOTE: every flop uses non-blocking assignment so that s2 samples the old
  // s1 on the same edge; blocking would collapse the two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= req_in;
      s2 <= s1;
    end
  end

  // -------------------------------------------------------------------------
  // Accept detection: s2 differs from the accepted level and has done so for
  // DEBOUNCE_CYCLES consecutive edges (counter already at its maximum).
  // -------------------------------------------------------------------------
  // NOTE: each always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    accept = '0;
    rise   = '0;
    for (int i = 0; i < NCH; i++) begin
      accept[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_MAX);
      rise[i]   = accept[i] && s2[i];
    end
  end

  // -------------------------------------------------------------------------
  // Debounce counters and accepted level. Any return of s2 to the accepted
  // level before acceptance restarts the count from zero.
  // -------------------------------------------------------------------------
  // NOTE: the counters and the stable level are ordinary flops, not a memory,
  // so they are all cleared by reset; a reset mid-count discards the partial
  // count and a still-held input is seen as a fresh press afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Acknowledge decode: at most one channel cleared per cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    clr = '0;
    if (ack_valid) begin
      clr[ack_idx] = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Pending and overflow next state.
  //   pend: a new rise beats a simultaneous clear (the new event supersedes
  //         the one just serviced); an ack to an idle channel is harmless.
  //   ovf:  a rise onto a channel that stays pending is an overflow; a rise
  //         coinciding with that channel's clear is not. A new overflow
  //         beats ovf_clr on the same edge.
  // -------------------------------------------------------------------------
  always_comb begin
    pend_next = pend;
    ovf_next  = ovf_clr ? '0 : ovf;
    for (int i = 0; i < NCH; i++) begin
      if (rise[i]) begin
        pend_next[i] = 1'b1;
      end else if (clr[i]) begin
        pend_next[i] = 1'b0;
      end

      if (rise[i] && pend[i] && !clr[i]) begin
        ovf_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      ovf  <= '0;
    end else begin
      pend <= pend_next;
      ovf  <= ovf_next;
    end
  end

  assign any_pend = |pend;

endmodule

// File: doc/req_capture.md
Name: req_capture

Overview:
- Upstream request-capture stage for the 4-to-2 priority encoder.
- Takes four raw, asynchronous request lines (push-buttons or switches) and synchronises and debounces each one.
- Latches each debounced rising edge into a pending bit. The 4-bit pending vector drives the encoder's `a[3:0]` input directly.
- The consumer returns an acknowledge carrying the serviced 2-bit index, and the matching pending bit is cleared. Index 3 is highest priority downstream.

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles a synchronised level must hold before it is accepted. Legal range is 1 to 65535.
- `CW`, default `$clog2(DEBOUNCE_CYCLES+1)`: width of the per-channel debounce counter. Derived from `DEBOUNCE_CYCLES`; do not override.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_in` input 4: raw asynchronous request lines, active-high.
- `ack_valid` input 1: one-cycle pulse; the consumer has serviced request `ack_idx`.
- `ack_idx` input 2: index of the serviced request. Sampled only when `ack_valid` = 1.
- `ovf_clr` input 1: clears all overflow flags.
- `pend` output 4: pending request vector, goes to the encoder `a[3:0]`.
- `any_pend` output 1: OR-reduction of `pend`.
- `ovf` output 4: sticky per-channel flag, set when a new request arrives on a channel that is already pending.

Behaviour:
- Reset (`rst_n` = 0, any time, asynchronous) clears all of the following to 0:
  - `pend`, `any_pend`, `ovf`
  - both synchroniser stages `s1[3:0]` and `s2[3:0]`
  - debounced level `stable[3:0]`
  - all debounce counters
- Reset mid-debounce or with pending bits set discards all state. After `rst_n` deasserts, a held-high input is treated as a new press: it produces a pend set after full latency.
- Synchroniser, per channel: `s1 <= req_in[i]`, then `s2 <= s1`. There is no other use of `req_in`.
- Debounce, per channel `i`, each edge:
  - If `s2[i] == stable[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `stable[i] <= s2[i]` and `cnt[i] <= 0`. This is the "accept" event.
  - Else: `cnt[i] <= cnt[i]+1`.
  - Any glitch that returns `s2` to `stable` before acceptance restarts the count from 0.
- Rising event `rise[i]`: an accept with `s2[i] = 1`. Falling accepts only update `stable`; they never touch `pend` or `ovf`.
- Latency: the first clock edge that samples the new `req_in` level is edge 1. `rise`/`pend` update on edge `DEBOUNCE_CYCLES+2`, provided the level holds throughout.
- Clear condition: `clr[i] = ack_valid & (ack_idx == i)`. At most one channel is cleared per cycle.
- Pend update, priority order:
  - `rise[i]`: `pend[i] <= 1`. Set wins over a simultaneous clear, because a new event supersedes the serviced one.
  - Else `clr[i]`: `pend[i] <= 0`.
  - Else hold.
- Ack to a channel whose pend bit is 0: no effect, no error.
- Overflow:
  - `ovf[i] <= 1` when `rise[i]` occurs and `pend[i] == 1` and `clr[i] == 0`.
  - Same-cycle rise with clear is not an overflow.
  - `ovf_clr` clears all bits on the next edge; a simultaneous overflow set wins over `ovf_clr`.
- Output timing: `pend` and `ovf` are registered outputs. `any_pend` is combinational OR of registered `pend`, so it has no extra latency.
- Channels are fully independent, and all four may accept on the same edge.

Test Plan:
- Reset, then raise `req_in` = 0001 and hold (`DEBOUNCE_CYCLES` = 4) -> `pend` = 0000 through edge 5, `pend` = 0001 and `any_pend` = 1 after edge 6.
- Bounce on `req_in[2]`: high 2 cycles, low 1, high 2, low, repeated -> `pend[2]` never sets. A clean high held for 6+ cycles -> `pend[2]` = 1 after edge 6 of the clean run.
- `pend` = 1010, pulse `ack_valid` with `ack_idx` = 3 -> `pend` = 0010 next edge. Ack with idx 0 -> `pend` unchanged at 0010, `ovf` = 0000.
- Channel 1 pending; release and re-press (each held ≥ 6 cycles) with no ack -> `ovf` = 0010 and `pend` = 0010. Then pulse `ovf_clr` -> `ovf` = 0000.
- Rise on channel 0 lands on the same edge as `ack_valid` with `ack_idx` = 0 while `pend[0]` = 1 -> `pend[0]` stays 1, `ovf[0]` stays 0.
- Press all four simultaneously, then assert `rst_n` = 0 mid-count (edge 4) and release after 2 cycles with inputs still high -> all outputs 0 during reset. `pend` = 1111 on edge 6 after reset release.
